pipe_sel_mux: RTL

//  Parametrised N-way datapath select stage with registered output and valid/ready flow control.

---
 rtl/mips_dp_pkg.sv | 18 +
 rtl/sel_ext_core.sv | 42 ++++
 rtl/pipe_sel_mux.sv | 97 +++++++++
 3 files changed

// File: rtl/mips_dp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_dp_pkg : shared datapath-mux constants and beat payload type |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mips_dp_pkg;

   localparam int EXT_ZERO = 0;
   localparam int EXT_SIGN = 1;
   localparam int DP_W     = 32;

   typedef struct packed {
      logic            err;
      logic [DP_W-1:0] data;
   } dp_beat_t;

endpackage
`default_nettype wire

// File: rtl/sel_ext_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sel_ext_core : combinational operand select, extend and err flag  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sel_ext_core
   import mips_dp_pkg::*;
#(
   parameter int IN_W     = 32,
   parameter int OUT_W    = 32,
   parameter int NUM_IN   = 3,
   parameter int EXT_MODE = EXT_ZERO,
   parameter int SEL_W    = $clog2(NUM_IN)
) (
   input  logic [NUM_IN*IN_W-1:0] in_data,
   input  logic [SEL_W-1:0]       in_sel,
   output logic [OUT_W-1:0]       out_data,
   output logic                   out_err
);

   logic [IN_W-1:0] w_op;

   // Out-of-range selects leave w_op at zero so illegal beats carry data 0.
   always_comb begin
      w_op = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (in_sel == SEL_W'(k)) w_op = in_data[k*IN_W +: IN_W];
      end
   end

   assign out_err = (int'(in_sel) >= NUM_IN);

   if (OUT_W == IN_W) begin : g_pass
      assign out_data = w_op;
   end else if (EXT_MODE == EXT_SIGN) begin : g_sign
      assign out_data = {{(OUT_W-IN_W){w_op[IN_W-1]}}, w_op};
   end else begin : g_zero
      assign out_data = {{(OUT_W-IN_W){1'b0}}, w_op};
   end

endmodule
`default_nettype wire

// File: rtl/pipe_sel_mux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_sel_mux : N-way select/extend stage with main+skid buffer    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pipe_sel_mux
   import mips_dp_pkg::*;
#(
   parameter int IN_W     = 32,
   parameter int OUT_W    = 32,
   parameter int NUM_IN   = 3,
   parameter int EXT_MODE = EXT_ZERO,
   parameter int SEL_W    = $clog2(NUM_IN)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_IN*IN_W-1:0] in_data,
   input  logic [SEL_W-1:0]       in_sel,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   flush,
   output logic [OUT_W-1:0]       out_data,
   output logic                   out_err,
   output logic                   out_valid,
   input  logic                   out_ready
);

   if (OUT_W < IN_W || NUM_IN < 2) begin : g_bad_param
      $fatal(1, "pipe_sel_mux: requires OUT_W >= IN_W and NUM_IN >= 2");
   end

   typedef struct packed {
      logic             err;
      logic [OUT_W-1:0] data;
   } beat_t;

   beat_t w_beat;
   beat_t r_main;
   beat_t r_skid;
   logic  r_main_valid;
   logic  r_skid_valid;
   logic  w_accept;
   logic  w_xfer;

   sel_ext_core #(
      .IN_W     (IN_W),
      .OUT_W    (OUT_W),
      .NUM_IN   (NUM_IN),
      .EXT_MODE (EXT_MODE),
      .SEL_W    (SEL_W)
   ) u_core (
      .in_data  (in_data),
      .in_sel   (in_sel),
      .out_data (w_beat.data),
      .out_err  (w_beat.err)
   );

   assign w_accept = in_valid & ~r_skid_valid;
   assign w_xfer   = r_main_valid & out_ready;

   // Skid can only be occupied while main is, so main-empty implies skid-empty.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_main       <= '0;
         r_skid       <= '0;
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (!r_main_valid) begin
         if (w_accept) begin
            r_main       <= w_beat;
            r_main_valid <= 1'b1;
         end
      end else if (w_xfer) begin
         if (r_skid_valid) begin
            r_main       <= r_skid;
            r_skid_valid <= 1'b0;
         end else if (w_accept) begin
            r_main <= w_beat;
         end else begin
            r_main_valid <= 1'b0;
         end
      end else if (w_accept) begin
         r_skid       <= w_beat;
         r_skid_valid <= 1'b1;
      end
   end

   assign in_ready  = ~r_skid_valid;
   assign out_valid = r_main_valid;
   assign out_data  = r_main.data;
   assign out_err   = r_main.err;

endmodule
`default_nettype wire
